// File: rtl/booth_mult_core_if.sv
// Handshake and operand bundle for booth_mult_core: request side drives start/operands,
// core side returns the registered product and status flags.
interface booth_mult_core_if #(
  parameter int N = 4
);
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [2*N:0]   mix_reg;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  modport master (
    output start, multiplicand, mix_reg,
    input  product, busy, done
  );

  modport slave (
    input  start, multiplicand, mix_reg,
    output product, busy, done
  );
endinterface

// File: rtl/booth_mult_core.sv
// Radix-2 Booth sequential multiplier: captures a seeded working register, runs N add/shift
// steps, then presents the signed 2N-bit product with a one-cycle done pulse.
module booth_mult_core #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  booth_mult_core_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  // Accumulator carries one guard bit so subtracting the most negative M cannot overflow.
  logic [N:0]     acc_r;
  logic [N-1:0]   q_r;
  logic           qm1_r;
  logic [N-1:0]   m_r;
  logic [CW-1:0]  cnt_r;
  logic [2*N-1:0] product_r;
  logic           busy_r;
  logic           done_r;

  logic [N:0]     m_ext_s;
  logic [N:0]     sum_s;
  logic [N:0]     acc_nx_s;
  logic [N-1:0]   q_nx_s;
  logic           qm1_nx_s;
  logic           last_step_s;

  assign bus.product = product_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

  // Next-state decode for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_nx_s  = state_r;
    last_step_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nx_s = CALC;
        else           state_nx_s = IDLE;
      end
      CALC: begin
        last_step_s = (cnt_r == CW'(N - 1));
        if (last_step_s) state_nx_s = DONE;
        else             state_nx_s = CALC;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // One Booth step: conditional add/subtract followed by an arithmetic right shift.
  always_comb begin
    m_ext_s = {m_r[N-1], m_r};
    sum_s   = acc_r;
    case ({q_r[0], qm1_r})
      2'b01:   sum_s = acc_r + m_ext_s;
      2'b10:   sum_s = acc_r - m_ext_s;
      default: sum_s = acc_r;
    endcase
    acc_nx_s = {sum_s[N], sum_s[N:1]};
    q_nx_s   = {sum_s[0], q_r[N-1:1]};
    qm1_nx_s = q_r[0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nx_s;
  end

  // Working register, counter, product and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r     <= '0;
      q_r       <= '0;
      qm1_r     <= 1'b0;
      m_r       <= '0;
      cnt_r     <= '0;
      product_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == CALC);
      done_r <= (state_nx_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            acc_r <= {bus.mix_reg[2*N], bus.mix_reg[2*N:N+1]};
            q_r   <= bus.mix_reg[N:1];
            qm1_r <= bus.mix_reg[0];
            m_r   <= bus.multiplicand;
            cnt_r <= '0;
          end
        end
        CALC: begin
          acc_r <= acc_nx_s;
          q_r   <= q_nx_s;
          qm1_r <= qm1_nx_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_step_s) product_r <= {acc_nx_s[N-1:0], q_nx_s};
        end
        default: begin
        end
      endcase
    end
  end
endmodule
